// File: rtl/vx_rsp_demux_if.sv
// vx_rsp_demux_if: response-side handshake bundle between the upstream stream and the per-requester channels.
interface vx_rsp_demux_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32,
  parameter int SELW = 2
);
  logic                      valid_in;
  logic [DATAW-1:0]          data_in;
  logic [SELW-1:0]           sel_in;
  logic                      ready_in;
  logic [NUM_REQS-1:0]       valid_out;
  logic [NUM_REQS*DATAW-1:0] data_out;
  logic [NUM_REQS-1:0]       ready_out;
  modport master (output valid_in, data_in, sel_in, ready_out, input ready_in, valid_out, data_out);
  modport slave (input valid_in, data_in, sel_in, ready_out, output ready_in, valid_out, data_out);
endinterface

// File: rtl/vx_rsp_demux.sv
// vx_rsp_demux: routes a tagged response stream to per-requester channels with optional per-channel buffering.
module vx_rsp_demux #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 32,
  parameter int BUFFERED = 1,
  parameter int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input logic clk,
  input logic reset,
  vx_rsp_demux_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic [SELW-1:0] sel;
  logic [(1<<SELW)-1:0] acc_ext;
  logic [NUM_REQS-1:0] can_acc, push, pop, vld;
  logic [NUM_REQS-1:0][DATAW-1:0] dat;
  // Unused select codes read as "can accept" so out-of-range beats are swallowed.
  always_comb begin
    sel = (NUM_REQS == 1) ? '0 : bus.sel_in;
    acc_ext = '1;
    acc_ext[NUM_REQS-1:0] = can_acc;
    bus.ready_in = (BUFFERED != 0 && reset) ? 1'b0 : acc_ext[sel];
  end
  assign bus.valid_out = vld;
  assign bus.data_out = dat;
  assign pop = vld & bus.ready_out;
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_ch
    assign push[g] = bus.valid_in && bus.ready_in && sel == SELW'(g);
    if (BUFFERED == 0) begin : g_pass
      assign can_acc[g] = bus.ready_out[g];
      assign vld[g] = bus.valid_in && sel == SELW'(g);
      assign dat[g] = bus.data_in;
    end else if (BUFFERED == 2) begin : g_pipe
      logic valid_q;
      logic [DATAW-1:0] data_q;
      always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else if (push[g]) valid_q <= 1'b1;
        else if (pop[g]) valid_q <= 1'b0;
        if (push[g]) data_q <= bus.data_in;
      end
      assign vld[g] = valid_q && !reset;
      assign can_acc[g] = !vld[g] || bus.ready_out[g];
      assign dat[g] = data_q;
    end else begin : g_skid
      state_t state_q, state_d;
      logic [DATAW-1:0] out_q, skid_q;
      logic vld_c, acc_c;
      always_ff @(posedge clk) begin
        state_q <= reset ? EMPTY : state_d;
      end
      always_comb begin
        state_d = state_q;
        if (state_q == EMPTY && push[g]) state_d = ONE;
        else if (state_q == ONE && push[g] != pop[g]) state_d = push[g] ? TWO : EMPTY;
        else if (state_q == TWO && pop[g]) state_d = ONE;
      end
      always_comb begin
        vld_c = state_q != EMPTY && !reset;
        acc_c = state_q != TWO;
      end
      // Skid only fills when the output register is occupied and not draining.
      always_ff @(posedge clk) begin
        if (push[g] && (state_q == EMPTY || pop[g])) out_q <= bus.data_in;
        else if (push[g]) skid_q <= bus.data_in;
        else if (pop[g] && state_q == TWO) out_q <= skid_q;
      end
      assign vld[g] = vld_c;
      assign can_acc[g] = acc_c;
      assign dat[g] = out_q;
    end
  end
endmodule
